// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: pops the byte FIFO while there is room downstream, absorbs
// the one-cycle FIFO read latency in a 2-entry skid buffer, and presents the
// words in FIFO order on a valid/ready stream.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  pop_count,
  output logic                  err_underflow,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                          state, state_nxt;
  logic [1:0]                      occ;       // skid entries held, 0..2
  logic                            inflight;  // fifo_rd was high last cycle
  logic [1:0][DATA_WIDTH-1:0]      skid;      // [0] is the head
  logic                            pop, cap;
  logic [2:0]                      level;

  assign pop     = m_valid & m_ready;
  assign cap     = inflight & ~fifo_underflow;
  assign m_valid = (occ != 2'd0);
  assign m_data  = skid[0];
  assign busy    = (state != IDLE);

  // Words already held or on their way back from the FIFO; a pop this cycle
  // frees a slot early, which lets reads resume with the first accepted beat.
  assign level   = {1'b0, occ} + {2'b0, inflight};
  assign fifo_rd = enable & ~fifo_empty & (state == RUN) &
                   (level < (3'd2 + {2'b0, pop}));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: leave RUN when disabled, linger in DRAIN until nothing is
  // buffered or outstanding
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable) state_nxt = RUN;
      RUN:   if (!enable) state_nxt = (occ != 2'd0 || inflight) ? DRAIN : IDLE;
      DRAIN: if (enable) state_nxt = RUN;
             else if (occ == 2'd0 && !inflight) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-latency tracking and sticky underflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (inflight && fifo_underflow) err_underflow <= 1'b1;
    end
  end

  // Skid buffer: capture at the tail, shift toward the head on pop.
  // The issue rule keeps occ + inflight <= 2, so a capture never overflows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ  <= 2'd0;
      skid <= '0;
    end else begin
      case ({pop, cap})
        2'b10: begin
          skid[0] <= skid[1];
          occ     <= occ - 2'd1;
        end
        2'b01: begin
          skid[occ[0]] <= fifo_data;
          occ          <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid[0] <= fifo_data;
          end else begin
            skid[0] <= skid[1];
            skid[1] <= fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Accepted-transfer counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    pop_count <= '0;
    else if (pop) pop_count <= pop_count + 1'b1;
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a 16-bit counter instance and a 4-bit counter
// instance share the same stimulus and a simple FIFO model with one-cycle
// read latency.
module tb_fifo_read_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, m_ready, force_uf;
  logic        fifo_empty, fifo_underflow, uf_q;
  logic [7:0]  fifo_data;
  logic        fifo_rd, m_valid, err, busy;
  logic [7:0]  m_data;
  logic [15:0] cnt;
  logic        fifo_rd4, m_valid4, err4, busy4;
  logic [7:0]  m_data4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  fifo_read_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .pop_count(cnt),
    .err_underflow(err), .busy(busy));

  fifo_read_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_data(fifo_data), .fifo_rd(fifo_rd4),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready), .pop_count(cnt4),
    .err_underflow(err4), .busy(busy4));

  // FIFO model: writes from the stimulus, pops on fifo_rd with 1-cycle latency
  logic [7:0] fmem [0:255];
  int         wp = 0, rp = 0;
  assign fifo_empty     = (wp == rp);
  assign fifo_underflow = uf_q | force_uf;

  initial begin
    fifo_data = 8'h00;
    uf_q      = 1'b0;
  end

  // FIFO read port
  always @(posedge clk) begin
    if (fifo_rd) begin
      if (rp != wp) begin
        fifo_data <= fmem[rp[7:0]];
        rp        <= rp + 1;
        uf_q      <= 1'b0;
      end else begin
        uf_q <= 1'b1;
      end
    end else begin
      uf_q <= 1'b0;
    end
  end

  // Stream monitor
  logic [7:0] rx [$];
  always @(negedge clk)
    if (!reset && m_valid && m_ready) rx.push_back(m_data);

  int nvec = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp[7:0]] = b;
    wp = wp + 1;
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic chk_rx(input string nm, input logic [7:0] base, input int n);
    chk({nm, " count"}, rx.size(), n);
    for (int i = 0; i < n; i++)
      if (i < rx.size()) chk(nm, rx[i], base + i[7:0]);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " rd"},   {fifo_rd, fifo_rd4}, 2'b00);
    chk({nm, " vld"},  {m_valid, m_valid4}, 2'b00);
    chk({nm, " data"}, {m_data, m_data4},   16'h0000);
    chk({nm, " cnt"},  {cnt, cnt4},         20'h00000);
    chk({nm, " err"},  {err, err4},         2'b00);
    chk({nm, " busy"}, {busy, busy4},       2'b00);
  endtask

  task automatic wait_rx(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (rx.size() >= n) break;
    end
  endtask

  typedef struct {
    logic        en, rdy, k_data;
    logic        rd, vld;
    logic [7:0]  data;
    logic [15:0] cnt;
    logic        bsy;
  } vec_t;

  vec_t tv [9];

  initial begin
    int   npulse;
    logic wrap;
    logic [3:0] prev4;
    logic [4:0] bexp;

    tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0, 1'b0};
    tv[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 1'b1};
    tv[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0, 1'b1};
    tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 16'd0, 1'b1};
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 16'd1, 1'b1};
    tv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 16'd2, 1'b1};
    tv[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 16'd3, 1'b1};
    tv[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4, 1'b1};
    tv[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'd4, 1'b1};

    reset = 1'b1; enable = 1'b0; m_ready = 1'b0; force_uf = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h10 + i[7:0]);
    #12;
    chk_reset("reset");

    // Preloaded stream, table-driven
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      enable  = tv[i].en;
      m_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d rd", i),  fifo_rd, tv[i].rd);
      chk($sformatf("v%0d vld", i), m_valid, tv[i].vld);
      if (tv[i].k_data) chk($sformatf("v%0d data", i), m_data, tv[i].data);
      chk($sformatf("v%0d cnt", i),  cnt, tv[i].cnt);
      chk($sformatf("v%0d cnt4", i), cnt4, tv[i].cnt[3:0]);
      chk($sformatf("v%0d busy", i), busy, tv[i].bsy);
      cyc();
    end

    // Backpressure: 10-cycle stall with 8 words available
    rx.delete();
    for (int i = 0; i < 8; i++) push(8'hA0 + i[7:0]);
    m_ready = 1'b0;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd) npulse++;
      if (i >= 2) chk($sformatf("stall%0d head", i), {m_valid, m_data}, {1'b1, 8'hA0});
      cyc();
    end
    chk("stall rd pulses", npulse, 2);
    m_ready = 1'b1;
    @(negedge clk);
    chk("release rd", {fifo_rd, m_valid}, 2'b11);
    wait_rx(8, 40);
    chk_rx("bp order", 8'hA0, 8);
    chk("bp cnt",  cnt, 16'd12);
    chk("bp cnt4", cnt4, 4'd12);

    // Enable dropped mid-stream for 5 cycles
    rx.delete();
    for (int i = 0; i < 10; i++) push(8'hB0 + i[7:0]);
    for (int i = 0; i < 4; i++) cyc();
    enable = 1'b0;
    bexp = 5'b00111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("drop%0d rd", i), fifo_rd, 1'b0);
      chk($sformatf("drop%0d busy", i), busy, bexp[i]);
      cyc();
    end
    enable = 1'b1;
    wait_rx(10, 40);
    chk_rx("drop order", 8'hB0, 10);
    chk("drop cnt", cnt, 16'd22);

    // Forced underflow on a returning read
    for (int i = 0; i < 3; i++) cyc();
    rx.delete();
    push(8'hC0);
    @(negedge clk);
    chk("uf rd", fifo_rd, 1'b1);
    cyc();
    force_uf = 1'b1;
    @(negedge clk);
    chk("uf err early", err, 1'b0);
    cyc();
    force_uf = 1'b0;
    @(negedge clk);
    chk("uf err set", {err, err4, m_valid}, 3'b110);
    for (int i = 0; i < 3; i++) cyc();
    chk("uf err sticky", err, 1'b1);
    chk("uf cnt", cnt, 16'd22);
    push(8'hC1);
    for (int i = 0; i < 6; i++) cyc();
    chk_rx("uf rx", 8'hC1, 1);
    chk("uf cnt after", {cnt, cnt4}, {16'd23, 4'd7});

    // Asynchronous reset with a full skid buffer
    rx.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'hD0 + i[7:0]);
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    chk("full head", {m_valid, m_data}, {1'b1, 8'hD0});
    #2 reset = 1'b1;
    #1 chk_reset("async");
    @(posedge clk); #1;
    reset = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    chk("post-reset rd c0", fifo_rd, 1'b0);
    cyc();
    @(negedge clk);
    chk("post-reset rd c1", fifo_rd, 1'b1);
    wait_rx(3, 20);
    chk_rx("post-reset rx", 8'hD2, 3);
    chk("post-reset cnt", cnt, 16'd3);

    // Counter wrap on the 4-bit instance
    @(negedge clk);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rx.delete();
    for (int i = 0; i < 17; i++) push(8'h40 + i[7:0]);
    wrap  = 1'b0;
    prev4 = 4'd0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (prev4 == 4'hF && cnt4 == 4'h0) wrap = 1'b1;
      prev4 = cnt4;
      if (rx.size() >= 17) break;
    end
    @(negedge clk);
    chk_rx("wrap rx", 8'h40, 17);
    chk("wrap seen", wrap, 1'b1);
    chk("wrap cnt4", cnt4, 4'd1);
    chk("wrap cnt16", cnt, 16'd17);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
